// File: rtl/qcw_bridge_osc_if.sv
// Configuration and gate-word bundle of the QCW full-bridge oscillator.
// The master side drives period/phase/dead-time requests; the slave side returns the gate words.
interface qcw_bridge_osc_if #(
    parameter int CNT_W = 24,
    parameter int SER_W = 8,
    parameter int DT_W  = 8
);
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] b_phase;
    logic [DT_W-1:0]  dead_time;
    logic             latch;
    logic             enable;
    logic             out_ref;
    logic [SER_W-1:0] GDT1_A_word;
    logic [SER_W-1:0] GDT1_B_word;
    logic [SER_W-1:0] GDT2_A_word;
    logic [SER_W-1:0] GDT2_B_word;
    logic             running;
    logic             cfg_err;

    modport master (
        output period, b_phase, dead_time, latch, enable,
        input  out_ref, GDT1_A_word, GDT1_B_word, GDT2_A_word, GDT2_B_word, running, cfg_err
    );
    modport slave (
        input  period, b_phase, dead_time, latch, enable,
        output out_ref, GDT1_A_word, GDT1_B_word, GDT2_A_word, GDT2_B_word, running, cfg_err
    );
endinterface

// File: rtl/qcw_bridge_osc.sv
// Full-bridge QCW oscillator emitting SER_W-tick gate words per clock, with dead time and reload.
// Optional macro QCW_PHASE_SHIFT_EN enables an independently phase-shifted second leg.
module qcw_bridge_osc #(
    parameter int CNT_W = 24,
    parameter int SER_W = 8,
    parameter int DT_W  = 8
) (
    input logic         clk_logic,
    input logic         reset,
    qcw_bridge_osc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [CNT_W:0]   SER_X   = (CNT_W+1)'(SER_W);
    localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(4 * SER_W);

    state_t           state;
    logic [CNT_W-1:0] pos, per_l, half_l;
    logic [DT_W-1:0]  dead_l;
    logic             pend;
`ifdef QCW_PHASE_SHIFT_EN
    logic [CNT_W-1:0] b_l, b_new, b_s;
`endif

    logic [CNT_W:0]   end_x, next_x, t;
    logic [CNT_W-1:0] next_pos, p, per_s, half_s;
    logic [DT_W-1:0]  dead_s;
    logic             wrap_word, stop_now, reload_now, new_ok, abort, post, use_new, kill;
    logic [1:0]       l1, l2;
    logic [SER_W-1:0] a1_w, b1_w, a2_w, b2_w;

    // Returns {B, A} for one tick; B absorbs the extra tick of an odd period.
    function automatic logic [1:0] leg_bits(input logic [CNT_W-1:0] pp, input logic [CNT_W-1:0] half,
                                            input logic [CNT_W-1:0] per, input logic [DT_W-1:0] dead);
        logic [CNT_W:0] d, hd;
        d  = (CNT_W+1)'(dead);
        hd = {1'b0, half} + d;
        if (d >= {1'b0, half}) return 2'b00;
        return {({1'b0, pp} >= hd) && (pp < per), ({1'b0, pp} >= d) && (pp < half)};
    endfunction

`ifdef QCW_PHASE_SHIFT_EN
    function automatic logic [CNT_W-1:0] shift_q(input logic [CNT_W-1:0] pp, input logic [CNT_W-1:0] b,
                                                 input logic [CNT_W-1:0] per);
        logic signed [CNT_W+1:0] q;
        q = $signed({2'b00, pp}) - $signed({2'b00, b});
        if (q < 0) q = q + $signed({2'b00, per});
        return q[CNT_W-1:0];
    endfunction

    assign b_new = (bus.b_phase >= bus.period) ? '0 : bus.b_phase;
`endif

    assign end_x      = {1'b0, pos} + SER_X;
    assign wrap_word  = end_x >= {1'b0, per_l};
    assign next_x     = wrap_word ? end_x - {1'b0, per_l} : end_x;
    assign next_pos   = next_x[CNT_W-1:0];
    assign stop_now   = (state == STOP) && !bus.enable && wrap_word;
    assign reload_now = (pend || bus.latch) && wrap_word && !stop_now;
    assign new_ok     = bus.period >= MIN_PER;
    assign abort      = reload_now && !new_ok;

    // Per-tick decode; ticks past the wrap take the reloaded settings or are blanked on stop/abort.
    always_comb begin
        a1_w = '0; b1_w = '0; a2_w = '0; b2_w = '0;
        t = '0; post = 1'b0; p = '0; use_new = 1'b0; kill = 1'b0;
        per_s = per_l; half_s = half_l; dead_s = dead_l; l1 = 2'b00; l2 = 2'b00;
`ifdef QCW_PHASE_SHIFT_EN
        b_s = b_l;
`endif
        for (int i = 0; i < SER_W; i++) begin
            t       = {1'b0, pos} + (CNT_W+1)'(i);
            post    = t >= {1'b0, per_l};
            p       = post ? CNT_W'(t - {1'b0, per_l}) : CNT_W'(t);
            use_new = post && reload_now;
            per_s   = use_new ? bus.period : per_l;
            half_s  = use_new ? (bus.period >> 1) : half_l;
            dead_s  = use_new ? bus.dead_time : dead_l;
            l1      = leg_bits(p, half_s, per_s, dead_s);
`ifdef QCW_PHASE_SHIFT_EN
            b_s     = use_new ? b_new : b_l;
            l2      = leg_bits(shift_q(p, b_s, per_s), half_s, per_s, dead_s);
`else
            l2      = {l1[0], l1[1]};
`endif
            kill    = post && (stop_now || abort);
            a1_w[i] = l1[0] && !kill;
            b1_w[i] = l1[1] && !kill;
            a2_w[i] = l2[0] && !kill;
            b2_w[i] = l2[1] && !kill;
        end
    end

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            state           <= IDLE;
            pos             <= '0;
            pend            <= 1'b0;
            bus.out_ref     <= 1'b0;
            bus.GDT1_A_word <= '0;
            bus.GDT1_B_word <= '0;
            bus.GDT2_A_word <= '0;
            bus.GDT2_B_word <= '0;
            bus.running     <= 1'b0;
            bus.cfg_err     <= 1'b0;
        end else begin
            bus.cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    pos             <= '0;
                    pend            <= 1'b0;
                    bus.out_ref     <= 1'b0;
                    bus.GDT1_A_word <= '0;
                    bus.GDT1_B_word <= '0;
                    bus.GDT2_A_word <= '0;
                    bus.GDT2_B_word <= '0;
                    bus.running     <= 1'b0;
                    if (bus.enable) begin
                        if (new_ok) begin
                            per_l       <= bus.period;
                            half_l      <= bus.period >> 1;
                            dead_l      <= bus.dead_time;
`ifdef QCW_PHASE_SHIFT_EN
                            b_l         <= b_new;
`endif
                            state       <= RUN;
                            bus.running <= 1'b1;
                        end else begin
                            bus.cfg_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    bus.GDT1_A_word <= a1_w;
                    bus.GDT1_B_word <= b1_w;
                    bus.GDT2_A_word <= a2_w;
                    bus.GDT2_B_word <= b2_w;
                    bus.out_ref     <= pos < half_l;
                    pos             <= next_pos;
                    pend            <= (pend || bus.latch) && !reload_now;
                    if (reload_now && new_ok) begin
                        per_l  <= bus.period;
                        half_l <= bus.period >> 1;
                        dead_l <= bus.dead_time;
`ifdef QCW_PHASE_SHIFT_EN
                        b_l    <= b_new;
`endif
                    end
                    if (abort || stop_now) begin
                        state       <= IDLE;
                        pos         <= '0;
                        pend        <= 1'b0;
                        bus.running <= 1'b0;
                        bus.cfg_err <= abort;
                    end else begin
                        state       <= bus.enable ? RUN : STOP;
                        bus.running <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qcw_bridge_osc.sv
// Directed bench for qcw_bridge_osc: vector table plus stop, resume, reload, reject and reset sequences.
module tb_qcw_bridge_osc;
    logic clk_logic = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    qcw_bridge_osc_if #(.CNT_W(24), .SER_W(8), .DT_W(8)) bus ();

    qcw_bridge_osc #(.CNT_W(24), .SER_W(8), .DT_W(8)) dut (
        .clk_logic (clk_logic),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_logic = ~clk_logic;

    typedef struct {
        logic [23:0] period;
        logic [23:0] b_phase;
        logic [7:0]  dead;
        int          k;
        logic [7:0]  a1, b1, a2, b2;
        logic        ref_v;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_logic);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.enable = 1'b0; bus.latch = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    // After return the DUT has sampled enable: RUN with pos=0, word k lands k+1 edges later.
    task automatic start(input logic [23:0] per, input logic [23:0] bp, input logic [7:0] dt);
        do_reset();
        bus.period = per; bus.b_phase = bp; bus.dead_time = dt; bus.enable = 1'b1;
        step(1);
    endtask

    initial begin
        logic [7:0] ea2, eb2;
        int refs;
        reset = 1'b1;
        bus.period = 24'd100; bus.b_phase = '0; bus.dead_time = '0;
        bus.latch = 1'b0; bus.enable = 1'b0;

        vecs[0]  = '{24'd100, 24'd0,   8'd0,  0,  8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1};
        vecs[1]  = '{24'd100, 24'd0,   8'd0,  6,  8'h03, 8'hFC, 8'h03, 8'hFC, 1'b1};
        vecs[2]  = '{24'd100, 24'd0,   8'd0,  12, 8'hF0, 8'h0F, 8'hF0, 8'h0F, 1'b0};
        vecs[3]  = '{24'd100, 24'd0,   8'd2,  0,  8'hFC, 8'h00, 8'hFC, 8'h00, 1'b1};
        vecs[4]  = '{24'd100, 24'd0,   8'd2,  6,  8'h03, 8'hF0, 8'h03, 8'hF0, 1'b1};
        vecs[5]  = '{24'd100, 24'd25,  8'd0,  0,  8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1};
        vecs[6]  = '{24'd100, 24'd25,  8'd0,  3,  8'hFF, 8'h00, 8'hFE, 8'h01, 1'b1};
        vecs[7]  = '{24'd101, 24'd0,   8'd0,  12, 8'hE0, 8'h1F, 8'hE0, 8'h1F, 1'b0};
        vecs[8]  = '{24'd100, 24'd0,   8'd50, 0,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[9]  = '{24'd100, 24'd150, 8'd0,  3,  8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1};
        vecs[10] = '{24'd32,  24'd0,   8'd0,  3,  8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[11] = '{24'd100, 24'd25,  8'd2,  3,  8'hFF, 8'h00, 8'hF8, 8'h01, 1'b1};

        do_reset();
        chk("reset_a1", 32'(bus.GDT1_A_word), 32'h0);
        chk("reset_b2", 32'(bus.GDT2_B_word), 32'h0);
        chk("reset_ref", 32'(bus.out_ref), 32'h0);
        chk("reset_running", 32'(bus.running), 32'h0);
        chk("reset_cfg_err", 32'(bus.cfg_err), 32'h0);

        for (int v = 0; v < 12; v++) begin
            start(vecs[v].period, vecs[v].b_phase, vecs[v].dead);
            step(vecs[v].k + 1);
`ifdef QCW_PHASE_SHIFT_EN
            ea2 = vecs[v].a2; eb2 = vecs[v].b2;
`else
            ea2 = vecs[v].b1; eb2 = vecs[v].a1;
`endif
            chk($sformatf("vec%0d_a1", v), 32'(bus.GDT1_A_word), 32'(vecs[v].a1));
            chk($sformatf("vec%0d_b1", v), 32'(bus.GDT1_B_word), 32'(vecs[v].b1));
            chk($sformatf("vec%0d_a2", v), 32'(bus.GDT2_A_word), 32'(ea2));
            chk($sformatf("vec%0d_b2", v), 32'(bus.GDT2_B_word), 32'(eb2));
            chk($sformatf("vec%0d_ref", v), 32'(bus.out_ref), 32'(vecs[v].ref_v));
            chk($sformatf("vec%0d_running", v), 32'(bus.running), 32'h1);
        end

        // No shoot-through in either leg across a full period with dead time.
        start(24'd100, 24'd25, 8'd2);
        for (int w = 0; w < 13; w++) begin
            step(1);
            chk($sformatf("overlap1_w%0d", w), 32'(bus.GDT1_A_word & bus.GDT1_B_word), 32'h0);
            chk($sformatf("overlap2_w%0d", w), 32'(bus.GDT2_A_word & bus.GDT2_B_word), 32'h0);
        end

        // Graceful stop: enable drops after word 3, the wrap word is truncated.
        start(24'd100, 24'd0, 8'd0);
        step(4);
        bus.enable = 1'b0;
        step(8);
        chk("stop_w11_b1", 32'(bus.GDT1_B_word), 32'hFF);
        chk("stop_w11_running", 32'(bus.running), 32'h1);
        step(1);
        chk("stop_wrap_a1", 32'(bus.GDT1_A_word), 32'h00);
        chk("stop_wrap_b1", 32'(bus.GDT1_B_word), 32'h0F);
        chk("stop_wrap_running", 32'(bus.running), 32'h0);
        step(1);
        chk("stop_after_a1", 32'(bus.GDT1_A_word), 32'h00);
        chk("stop_after_b1", 32'(bus.GDT1_B_word), 32'h00);
        chk("stop_after_a2", 32'(bus.GDT2_A_word), 32'h00);
        chk("stop_after_running", 32'(bus.running), 32'h0);

        // Resume from STOP before the wrap: no gap.
        start(24'd100, 24'd0, 8'd0);
        step(4);
        bus.enable = 1'b0;
        step(1);
        bus.enable = 1'b1;
        step(8);
        chk("resume_wrap_a1", 32'(bus.GDT1_A_word), 32'hF0);
        chk("resume_wrap_b1", 32'(bus.GDT1_B_word), 32'h0F);
        chk("resume_running", 32'(bus.running), 32'h1);

        // Reload 100 -> 200 mid-period; applies from the wrap tick.
        start(24'd100, 24'd0, 8'd0);
        step(4);
        bus.period = 24'd200; bus.latch = 1'b1;
        step(1);
        bus.latch = 1'b0;
        step(8);
        chk("reload_wrap_a1", 32'(bus.GDT1_A_word), 32'hF0);
        chk("reload_wrap_b1", 32'(bus.GDT1_B_word), 32'h0F);
        chk("reload_wrap_ref", 32'(bus.out_ref), 32'h0);
        refs = 0;
        for (int w = 0; w < 12; w++) begin
            step(1);
            if (bus.out_ref) refs++;
        end
        chk("reload_ref_words", 32'(refs), 32'd12);
        step(1);
        chk("reload_half_ref", 32'(bus.out_ref), 32'h0);
        chk("reload_half_a1", 32'(bus.GDT1_A_word), 32'h00);
        chk("reload_half_b1", 32'(bus.GDT1_B_word), 32'hFF);

        // Rejected start with a too-short period.
        do_reset();
        bus.period = 24'd20; bus.enable = 1'b1;
        step(1);
        bus.enable = 1'b0;
        chk("reject_cfg_err", 32'(bus.cfg_err), 32'h1);
        chk("reject_running", 32'(bus.running), 32'h0);
        step(1);
        chk("reject_cfg_err_clear", 32'(bus.cfg_err), 32'h0);
        chk("reject_idle_a1", 32'(bus.GDT1_A_word), 32'h0);

        // Reset mid-RUN clears everything at the next edge.
        start(24'd100, 24'd0, 8'd0);
        step(3);
        chk("prereset_a1", 32'(bus.GDT1_A_word), 32'hFF);
        reset = 1'b1;
        step(1);
        chk("midreset_a1", 32'(bus.GDT1_A_word), 32'h0);
        chk("midreset_b2", 32'(bus.GDT2_B_word), 32'h0);
        chk("midreset_ref", 32'(bus.out_ref), 32'h0);
        chk("midreset_running", 32'(bus.running), 32'h0);
        reset = 1'b0;
        bus.enable = 1'b0;
        step(2);
        chk("postreset_running", 32'(bus.running), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
